// File: rtl/divide.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : divide                                                        |
// | Purpose  : RV64M divide/remainder unit (DIV/DIVU/REM/REMU + W forms).    |
// |            Iterative radix-2 restoring divider, one quotient bit per     |
// |            cycle, one operation in flight.                               |
// | Options  : DIV_FAST_SPECIAL_EN - divide-by-zero and signed overflow are  |
// |            resolved at accept and skip the iterative path.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module divide #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            div_instr_i,
  input  logic [3:0]      div_func_i,
  input  logic            word_op_i,
  input  logic            flush_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] div_res_o,
  output logic            valid_res_o,
  output logic            div_busy_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  // Function encodings shared with the issue stage (RISC-V funct3 in low bits).
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_DIVU = 4'b0101;
  localparam logic [3:0] OP_REM  = 4'b0110;
  localparam logic [3:0] OP_REMU = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_DIVIDE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;         // raw captured dividend
  logic [XLEN-1:0] b_q, b_d;         // raw captured divisor
  logic [3:0]      func_q, func_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] quo_q, quo_d;     // dividend shifts out the top, quotient shifts in
  logic [XLEN-1:0] rem_q, rem_d;     // partial remainder, always < |b|
  logic [XLEN-1:0] babs_q, babs_d;   // |b|
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;

  function automatic logic is_signed_op(input logic [3:0] f);
    return (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [3:0] f);
    return (f == OP_REM) || (f == OP_REMU);
  endfunction

  // W-forms operate on the low half, sign- or zero-extended to full width.
  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] x,
                                             input logic word, input logic sgn);
    if (!word) return x;
    if (sgn)   return {{HALF{x[HALF-1]}}, x[HALF-1:0]};
    return {{HALF{1'b0}}, x[HALF-1:0]};
  endfunction

  // Returns {div_by_zero, signed_overflow} for the given raw operands.
  function automatic logic [1:0] special_detect(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic [3:0] f,
                                                input logic word);
    logic            sgn;
    logic [XLEN-1:0] ae, be, minv;
    logic            z, o;
    sgn  = is_signed_op(f);
    ae   = ext_op(a, word, sgn);
    be   = ext_op(b, word, sgn);
    minv = word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    z    = (be == '0);
    o    = sgn && !z && (ae == minv) && (be == '1);
    return {z, o};
  endfunction

  // Intermediate values for the FSM/datapath process.
  logic            sgn_w;
  logic [XLEN-1:0] a_ext_w, b_ext_w, abs_a_w, abs_b_w;
  logic            a_neg_w, b_neg_w;
  logic [XLEN:0]   rem_sh_w;
  logic            ge_w;
  logic [XLEN-1:0] q_fin_w, r_fin_w, sel_w;
  logic [1:0]      spec_w;
  logic [1:0]      spec_in_w;

  // Next-state, datapath and result computation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    func_d   = func_q;
    word_d   = word_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    babs_d   = babs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    res_d    = res_q;
    valid_d  = 1'b0;

    sgn_w     = is_signed_op(func_q);
    a_ext_w   = ext_op(a_q, word_q, sgn_w);
    b_ext_w   = ext_op(b_q, word_q, sgn_w);
    a_neg_w   = sgn_w & a_ext_w[XLEN-1];
    b_neg_w   = sgn_w & b_ext_w[XLEN-1];
    abs_a_w   = a_neg_w ? -a_ext_w : a_ext_w;
    abs_b_w   = b_neg_w ? -b_ext_w : b_ext_w;
    spec_w    = special_detect(a_q, b_q, func_q, word_q);
    spec_in_w = special_detect(opr_a_i, opr_b_i, div_func_i, word_op_i);

    rem_sh_w  = {rem_q, quo_q[XLEN-1]};
    ge_w      = (rem_sh_w >= {1'b0, babs_q});

    q_fin_w   = negq_q ? -quo_q : quo_q;
    r_fin_w   = negr_q ? -rem_q : rem_q;
    if (div0_q) begin
      q_fin_w = '1;
      r_fin_w = a_ext_w;
    end else if (ovf_q) begin
      q_fin_w = a_ext_w;
      r_fin_w = '0;
    end
    sel_w = is_rem_op(func_q) ? r_fin_w : q_fin_w;

    case (state_q)
      S_IDLE: begin
        if (div_instr_i && !kill_i && !flush_i) begin
          a_d    = opr_a_i;
          b_d    = opr_b_i;
          func_d = div_func_i;
          word_d = word_op_i;
`ifdef DIV_FAST_SPECIAL_EN
          div0_d  = spec_in_w[1];
          ovf_d   = spec_in_w[0];
          state_d = (spec_in_w != 2'b00) ? S_FINISH : S_SETUP;
`else
          state_d = S_SETUP;
`endif
        end
      end
      S_SETUP: begin
        // W-form dividend sits in the upper half so the MSB to consume is always the top bit.
        quo_d   = word_q ? (abs_a_w << HALF) : abs_a_w;
        rem_d   = '0;
        babs_d  = abs_b_w;
        negq_d  = a_neg_w ^ b_neg_w;
        negr_d  = a_neg_w;
        cnt_d   = word_q ? CW'(HALF - 1) : CW'(XLEN - 1);
        div0_d  = spec_w[1];
        ovf_d   = spec_w[0];
        state_d = flush_i ? S_IDLE : S_DIVIDE;
      end
      S_DIVIDE: begin
        rem_d = ge_w ? (rem_sh_w[XLEN-1:0] - babs_q) : rem_sh_w[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge_w};
        cnt_d = cnt_q - 1'b1;
        if (flush_i)            state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          res_d   = word_q ? {{HALF{sel_w[HALF-1]}}, sel_w[HALF-1:0]} : sel_w;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef DIV_FAST_SPECIAL_EN
  // Accept-time detection is only consumed by the fast-special build.
  logic unused_spec_in_w;
  assign unused_spec_in_w = ^spec_in_w;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      word_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      babs_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      word_q  <= word_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      babs_q  <= babs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign div_res_o   = res_q;
  assign valid_res_o = valid_q;
  assign div_busy_o  = (state_q != S_IDLE);

endmodule
`default_nettype wire
